id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register for the 64-bit RISC-V core. Captures the register file
//   read operands (ReadData1/ReadData2), immediate and decoded control for EX.
//   Provides a valid/ready handshake, pipeline flush and load-use stall detection.
//   Applies a write-back bypass, because the register file writes at posedge and
//   reads combinationally, so a same-cycle write is otherwise missed.
// PARAMETERS
//   XLEN       64  operand/PC/immediate width
//   RADDR_W    5   register index width
// PORTS
//   clk            in   1        clock, all state updates on posedge
//   reset          in   1        synchronous, active-high
//   id_valid       in   1        ID holds an instruction
//   id_ready       out  1        stage accepts the ID instruction this cycle
//   id_pc          in   XLEN     PC of ID instruction
//   id_rs1/id_rs2  in   RADDR_W  source indices
//   id_rd          in   RADDR_W  destination index
//   id_rdata1/2    in   XLEN     register file ReadData1/ReadData2
//   id_imm         in   XLEN     sign-extended immediate
//   id_ctrl        in   8        {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp[1:0]}
//   wb_reg_write   in   1        write-back write enable (same as reg file RegWrite)
//   wb_rd          in   RADDR_W  write-back destination
//   wb_data        in   XLEN     write-back data
//   flush          in   1        kill ID and EX contents (taken branch)
//   ex_ready       in   1        EX consumes ex_* this cycle
//   ex_valid       out  1        ex_* hold a live instruction
//   ex_pc/ex_imm   out  XLEN     registered copies
//   ex_rs1/ex_rs2/ex_rd out RADDR_W  registered indices
//   ex_op1/ex_op2  out  XLEN     registered operands, bypassed
//   ex_ctrl        out  8        registered control
//   load_use_stall out  1        combinational hazard flag
// BEHAVIOUR
//   Reset: ex_valid=0. All ex_* outputs = 0. load_use_stall and id_ready follow their
//     equations from the zeroed state, which gives id_ready=1.
//   load_use_stall = id_valid & ex_valid & ex_ctrl.MemRead & ex_rd!=0 &
//     (ex_rd==id_rs1 | ex_rd==id_rs2).
//   advance = ~ex_valid | ex_ready
//   id_ready = advance & ~load_use_stall & ~flush
//   Priority per posedge:
//     1. reset
//     2. flush: ex_valid<=0; ID is not captured.
//     3. advance & load_use_stall: insert bubble, ex_valid<=0; ID is held upstream.
//     4. advance & id_valid: capture all ID fields; ex_valid<=1.
//     5. advance & ~id_valid: ex_valid<=0.
//     6. otherwise (hold): all ex_* keep their value, except the held bypass below.
//   Capture bypass for each operand n (1,2):
//     rs==0 -> 0
//     else wb_reg_write & wb_rd==rs -> wb_data
//     else id_rdataN
//   Held bypass: while holding with ex_valid=1, if wb_reg_write & wb_rd!=0 &
//     wb_rd==ex_rsN, then ex_opN<=wb_data.
//   Latency: one cycle from ID capture to ex_* valid. No combinational path from
//     id_* to ex_*.
//   A bubble clears only ex_valid. Other ex_* fields are don't-care but must hold
//     stable values.
//   Width: no arithmetic; all fields are passed through unmodified.
//   The ex_ctrl.RegWrite/MemWrite bits are ANDed with ex_valid at the outputs, so a
//     bubble never writes.
// TESTING
//   Reset held 2 cycles -> ex_valid=0, ex_op1=ex_op2=0, id_ready=1.
//   Capture: id_valid=1, rs1=23, rs2=25, rdata1=3, rdata2=9, ex_ready=1
//     -> next cycle ex_valid=1, ex_op1=3, ex_op2=9, ex_rs1=23.
//   WB bypass: id_rs1=26, rdata1=4, wb_reg_write=1, wb_rd=26, wb_data=0x55
//     -> ex_op1=0x55. Repeat with wb_rd=0 or id_rs1=0 -> ex_op1 is rdata1 or 0.
//   Load-use: EX holds ld with rd=27; ID has add with rs2=27
//     -> load_use_stall=1, id_ready=0, next cycle ex_valid=0 (bubble).
//     The add is captured the following cycle.
//   Hold + held bypass: ex_ready=0 for 3 cycles with wb write to ex_rs2
//     -> ex_* stable except ex_op2=wb_data. No ID capture.
//   Flush while ex_ready=0 and id_valid=1 -> next cycle ex_valid=0, id_ready=0 during
//     flush. Reset asserted mid-hold -> ex_valid=0 next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands, immediate and control for EX,
// with valid/ready handshake, flush, load-use bubble insertion and write-back bypass.
module id_ex_stage #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               id_valid,
   output logic               id_ready,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [RADDR_W-1:0] id_rs1,
   input  logic [RADDR_W-1:0] id_rs2,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic [XLEN-1:0]    id_rdata1,
   input  logic [XLEN-1:0]    id_rdata2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic [7:0]         id_ctrl,
   input  logic               wb_reg_write,
   input  logic [RADDR_W-1:0] wb_rd,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               flush,
   input  logic               ex_ready,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [XLEN-1:0]    ex_imm,
   output logic [RADDR_W-1:0] ex_rs1,
   output logic [RADDR_W-1:0] ex_rs2,
   output logic [RADDR_W-1:0] ex_rd,
   output logic [XLEN-1:0]    ex_op1,
   output logic [XLEN-1:0]    ex_op2,
   output logic [7:0]         ex_ctrl,
   output logic               load_use_stall
);

   localparam int CtrlRegWrite = 7;
   localparam int CtrlMemRead  = 6;
   localparam int CtrlMemWrite = 5;

   logic               valid_q;
   logic [XLEN-1:0]    pc_q;
   logic [XLEN-1:0]    imm_q;
   logic [XLEN-1:0]    op1_q;
   logic [XLEN-1:0]    op2_q;
   logic [RADDR_W-1:0] rs1_q;
   logic [RADDR_W-1:0] rs2_q;
   logic [RADDR_W-1:0] rd_q;
   logic [7:0]         ctrl_q;
   logic               advance;
   logic [XLEN-1:0]    cap_op1;
   logic [XLEN-1:0]    cap_op2;

   // The register file writes at the same edge we capture, so its read data is stale
   // whenever write-back targets the register being read.
   function automatic logic [XLEN-1:0] bypass(input logic [RADDR_W-1:0] rs,
                                              input logic [XLEN-1:0]    rdata);
      if (rs == '0)
         return '0;
      else if (wb_reg_write && wb_rd == rs)
         return wb_data;
      else
         return rdata;
   endfunction

   always_comb begin
      load_use_stall = id_valid & valid_q & ctrl_q[CtrlMemRead] & (rd_q != '0) &
                       ((rd_q == id_rs1) | (rd_q == id_rs2));
      advance        = ~valid_q | ex_ready;
      id_ready       = advance & ~load_use_stall & ~flush;
      cap_op1        = bypass(id_rs1, id_rdata1);
      cap_op2        = bypass(id_rs2, id_rdata2);
   end

   // Bubbles and flushes clear only the valid bit; while EX stalls, a live instruction
   // keeps picking up write-back results for its source registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         imm_q   <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         ctrl_q  <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (advance) begin
         if (load_use_stall || !id_valid) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= 1'b1;
            pc_q    <= id_pc;
            imm_q   <= id_imm;
            op1_q   <= cap_op1;
            op2_q   <= cap_op2;
            rs1_q   <= id_rs1;
            rs2_q   <= id_rs2;
            rd_q    <= id_rd;
            ctrl_q  <= id_ctrl;
         end
      end else begin
         if (wb_reg_write && wb_rd != '0 && wb_rd == rs1_q)
            op1_q <= wb_data;
         if (wb_reg_write && wb_rd != '0 && wb_rd == rs2_q)
            op2_q <= wb_data;
      end
   end

   // RegWrite and MemWrite are gated so a bubble can never commit a side effect.
   assign ex_valid = valid_q;
   assign ex_pc    = pc_q;
   assign ex_imm   = imm_q;
   assign ex_op1   = op1_q;
   assign ex_op2   = op2_q;
   assign ex_rs1   = rs1_q;
   assign ex_rs2   = rs2_q;
   assign ex_rd    = rd_q;
   assign ex_ctrl  = {ctrl_q[CtrlRegWrite] & valid_q, ctrl_q[CtrlMemRead],
                      ctrl_q[CtrlMemWrite] & valid_q, ctrl_q[4:0]};

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a register-file-level model of the stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [63:0] id_rdata1;
   logic [63:0] id_rdata2;
   logic [63:0] id_imm;
   logic [7:0]  id_ctrl;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        flush;
   logic        ex_ready;
   logic        ex_valid;
   logic [63:0] ex_pc;
   logic [63:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [63:0] ex_op1;
   logic [63:0] ex_op2;
   logic [7:0]  ex_ctrl;
   logic        load_use_stall;

   int compared   = 0;
   int mismatched = 0;

   logic [63:0] rf [32];

   typedef struct packed {
      logic        v;
      logic [63:0] pc;
      logic [63:0] imm;
      logic [63:0] op1;
      logic [63:0] op2;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [7:0]  ctrl;
   } ex_state_t;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   // The bench owns the architectural register file; reads are combinational.
   always_comb begin
      id_rdata1 = rf[id_rs1];
      id_rdata2 = rf[id_rs2];
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [7:0] ctrl, input logic we,
                                input logic [4:0] wrd, input logic [63:0] wdata,
                                input logic fl, input logic rdy);
      id_valid     = v;
      id_pc        = {$urandom(), $urandom()};
      id_imm       = {$urandom(), $urandom()};
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_ctrl      = ctrl;
      wb_reg_write = we;
      wb_rd        = wrd;
      wb_data      = wdata;
      flush        = fl;
      ex_ready     = rdy;
      #1;
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   // Model: an instruction in EX carries operand values equal to the register file
   // contents after this edge's write-back, and keeps tracking them while it is held.
   initial begin
      ex_state_t   m;
      ex_state_t   mn;
      logic [63:0] rfNext [32];
      logic        live;
      logic        liveNext;
      logic        zeroed;
      logic        zeroedNext;
      logic        stall;
      logic        adv;
      logic        rdy;
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = {$urandom(), $urandom()};
      rf[23] = 64'd3;
      rf[25] = 64'd9;
      rf[26] = 64'd4;
      rf[28] = 64'd7;
      m      = '0;
      live   = 1'b0;
      zeroed = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         stall = id_valid && m.v && m.ctrl[6] && m.rd != 5'd0 &&
                 (m.rd == id_rs1 || m.rd == id_rs2);
         adv   = !m.v || ex_ready;
         rdy   = adv && !stall && !flush;
         if (live) begin
            checkOutput("model_stall", 64'(load_use_stall), 64'(stall));
            checkOutput("model_id_ready", 64'(id_ready), 64'(rdy));
            checkOutput("model_ex_valid", 64'(ex_valid), 64'(m.v));
            if (m.v || zeroed) begin
               checkOutput("model_pc", ex_pc, m.pc);
               checkOutput("model_imm", ex_imm, m.imm);
               checkOutput("model_rs1", 64'(ex_rs1), 64'(m.rs1));
               checkOutput("model_rs2", 64'(ex_rs2), 64'(m.rs2));
               checkOutput("model_rd", 64'(ex_rd), 64'(m.rd));
               checkOutput("model_op1", ex_op1, m.op1);
               checkOutput("model_op2", ex_op2, m.op2);
               checkOutput("model_ctrl", 64'(ex_ctrl), 64'(m.v ? m.ctrl : (m.ctrl & 8'h5F)));
            end else begin
               checkOutput("model_bubble_wr", 64'({ex_ctrl[7], ex_ctrl[5]}), 64'd0);
            end
         end
         rfNext = rf;
         if (wb_reg_write && wb_rd != 5'd0) rfNext[wb_rd] = wb_data;
         mn         = m;
         zeroedNext = 1'b0;
         liveNext   = live || reset;
         if (reset) begin
            mn         = '0;
            zeroedNext = 1'b1;
         end else if (flush || (adv && (stall || !id_valid))) begin
            mn.v = 1'b0;
         end else if (adv) begin
            mn.v    = 1'b1;
            mn.pc   = id_pc;
            mn.imm  = id_imm;
            mn.rs1  = id_rs1;
            mn.rs2  = id_rs2;
            mn.rd   = id_rd;
            mn.ctrl = id_ctrl;
            mn.op1  = rfNext[id_rs1];
            mn.op2  = rfNext[id_rs2];
         end else begin
            mn.op1 = rfNext[m.rs1];
            mn.op2 = rfNext[m.rs2];
         end
         @(posedge clk);
         #1;
         m      = mn;
         rf     = rfNext;
         live   = liveNext;
         zeroed = zeroedNext;
      end
   end

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 64'h0, 0, 1);
      tick;
      tick;
      checkOutput("reset_ex_valid", 64'(ex_valid), 64'd0);
      checkOutput("reset_op1", ex_op1, 64'd0);
      checkOutput("reset_op2", ex_op2, 64'd0);
      checkOutput("reset_id_ready", 64'(id_ready), 64'd1);
      reset = 1'b0;

      applyStimulus(1, 23, 25, 5, 8'h82, 0, 0, 64'h0, 0, 1);
      tick;
      checkOutput("cap_valid", 64'(ex_valid), 64'd1);
      checkOutput("cap_op1", ex_op1, 64'd3);
      checkOutput("cap_op2", ex_op2, 64'd9);
      checkOutput("cap_rs1", 64'(ex_rs1), 64'd23);

      applyStimulus(1, 26, 0, 6, 8'h82, 1, 26, 64'h55, 0, 1);
      tick;
      checkOutput("wb_bypass_op1", ex_op1, 64'h55);
      checkOutput("wb_bypass_op2_x0", ex_op2, 64'd0);
      applyStimulus(1, 28, 0, 6, 8'h82, 1, 0, 64'h99, 0, 1);
      tick;
      checkOutput("wb_rd0_op1", ex_op1, 64'd7);
      applyStimulus(1, 0, 0, 6, 8'h82, 1, 0, 64'h99, 0, 1);
      tick;
      checkOutput("rs1_zero_op1", ex_op1, 64'd0);

      applyStimulus(1, 1, 2, 27, 8'hD8, 0, 0, 64'h0, 0, 1);
      tick;
      applyStimulus(1, 3, 27, 8, 8'h82, 0, 0, 64'h0, 0, 1);
      checkOutput("lu_stall", 64'(load_use_stall), 64'd1);
      checkOutput("lu_id_ready", 64'(id_ready), 64'd0);
      tick;
      checkOutput("lu_bubble", 64'(ex_valid), 64'd0);
      #1;
      checkOutput("lu_ready_after", 64'(id_ready), 64'd1);
      tick;
      checkOutput("lu_add_valid", 64'(ex_valid), 64'd1);
      checkOutput("lu_add_rd", 64'(ex_rd), 64'd8);

      applyStimulus(1, 9, 10, 11, 8'h82, 1, 27, 64'hABCD, 0, 0);
      checkOutput("hold_id_ready", 64'(id_ready), 64'd0);
      tick;
      checkOutput("hold1_op2", ex_op2, 64'hABCD);
      applyStimulus(1, 9, 10, 11, 8'h82, 1, 27, 64'h1234, 0, 0);
      tick;
      checkOutput("hold2_op2", ex_op2, 64'h1234);
      applyStimulus(1, 9, 10, 11, 8'h82, 1, 27, 64'h5678, 0, 0);
      tick;
      checkOutput("hold3_op2", ex_op2, 64'h5678);
      checkOutput("hold3_rd", 64'(ex_rd), 64'd8);
      checkOutput("hold3_valid", 64'(ex_valid), 64'd1);

      applyStimulus(1, 9, 10, 11, 8'h82, 0, 0, 64'h0, 1, 0);
      checkOutput("flush_id_ready", 64'(id_ready), 64'd0);
      tick;
      checkOutput("flush_valid", 64'(ex_valid), 64'd0);
      checkOutput("flush_regwrite", 64'(ex_ctrl[7]), 64'd0);

      applyStimulus(1, 4, 5, 12, 8'h82, 0, 0, 64'h0, 0, 1);
      tick;
      applyStimulus(0, 4, 5, 12, 8'h82, 0, 0, 64'h0, 0, 0);
      tick;
      checkOutput("midhold_valid", 64'(ex_valid), 64'd1);
      reset = 1'b1;
      tick;
      checkOutput("midreset_valid", 64'(ex_valid), 64'd0);
      checkOutput("midreset_op1", ex_op1, 64'd0);
      reset = 1'b0;

      // Small register indices make hazards and bypass hits frequent.
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         applyStimulus(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 8'($urandom()),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       {$urandom(), $urandom()}, 1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 9) < 6));
         tick;
      end
      reset = 1'b0;
      tick;
      #5;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
